// File: rtl/spi_display_rx.sv
// SPI display-side receiver (mode 0, MSB first), oversampled by the system clock.
// Rebuilds {dc, byte} words and hands them to a sink through a put/full write port.
module spi_display_rx #(
    parameter int unsigned BITS = 8,
    parameter int unsigned SYNC = 2
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          spi_cs_n,
    input  logic          spi_clock,
    input  logic          spi_dc,
    input  logic          spi_mosi,
    output logic [BITS:0] data,
    output logic          put,
    input  logic          full,
    output logic          overrun,
    output logic          frame_err,
    input  logic          err_clear,
    output logic          busy
);

    localparam int unsigned CW = $clog2(BITS + 1);
    localparam int unsigned FW = $clog2(SYNC + 1);

    typedef enum logic [1:0] {
        S_WAIT,
        S_IDLE,
        S_SHIFT
    } state_t;

    // Synchronizer chains; all four pins share the same depth so mosi/dc stay aligned with sclk.
    logic [SYNC-1:0] cs_sync_q;
    logic [SYNC-1:0] sclk_sync_q;
    logic [SYNC-1:0] dc_sync_q;
    logic [SYNC-1:0] mosi_sync_q;
    logic            sclk_prev_q;

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [BITS-1:0] shift_q, shift_d;
    logic            dcw_q, dcw_d;
    logic            done_q, done_d;
    logic [FW-1:0]   flush_q, flush_d;
    logic [BITS:0]   data_q, data_d;
    logic            put_q, put_d;
    logic            overrun_q, overrun_d;
    logic            frame_err_q, frame_err_d;

    logic cs_s, sclk_s, dc_s, mosi_s, rise, flushed, fe_set, ov_set, deliver;

    assign cs_s    = cs_sync_q[SYNC-1];
    assign sclk_s  = sclk_sync_q[SYNC-1];
    assign dc_s    = dc_sync_q[SYNC-1];
    assign mosi_s  = mosi_sync_q[SYNC-1];
    assign rise    = sclk_s & ~sclk_prev_q;
    // The cs_n chain is preloaded high on reset; WAIT only trusts it once the
    // preload has been flushed out, otherwise a reset mid-transfer would leave
    // WAIT immediately and misalign on the next sclk rise.
    assign flushed = (flush_q == FW'(SYNC));

    // Pin synchronizers and sclk history for rise detection.
    always_ff @(posedge clock) begin
        if (reset) begin
            cs_sync_q   <= '1;
            sclk_sync_q <= '0;
            dc_sync_q   <= '0;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_sync_q   <= {cs_sync_q[SYNC-2:0], spi_cs_n};
            sclk_sync_q <= {sclk_sync_q[SYNC-2:0], spi_clock};
            dc_sync_q   <= {dc_sync_q[SYNC-2:0], spi_dc};
            mosi_sync_q <= {mosi_sync_q[SYNC-2:0], spi_mosi};
            sclk_prev_q <= sclk_s;
        end
    end

    // Next-state logic: framing FSM, bit shifter, word output stage and sticky flags.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        shift_d = shift_q;
        dcw_d   = dcw_q;
        done_d  = 1'b0;
        flush_d = flushed ? flush_q : flush_q + FW'(1);
        fe_set  = 1'b0;

        case (state_q)
            S_WAIT: begin
                if (flushed && cs_s) begin
                    state_d = S_IDLE;
                end
            end
            S_IDLE: begin
                if (!cs_s) begin
                    state_d = S_SHIFT;
                    count_d = '0;
                end
            end
            S_SHIFT: begin
                // A deselect takes priority over a coincident sclk rise.
                if (cs_s) begin
                    state_d = S_IDLE;
                    count_d = '0;
                    fe_set  = (count_q != '0);
                end else if (rise) begin
                    shift_d = {shift_q[BITS-2:0], mosi_s};
                    if (count_q == CW'(BITS - 1)) begin
                        count_d = '0;
                        done_d  = 1'b1;
                        dcw_d   = dc_s;
                    end else begin
                        count_d = count_q + CW'(1);
                    end
                end
            end
            default: begin
                state_d = S_WAIT;
            end
        endcase

        deliver = done_q & ~full;
        ov_set  = done_q & full;
        put_d   = deliver;
        data_d  = deliver ? {dcw_q, shift_q} : data_q;

        overrun_d   = ov_set ? 1'b1 : (err_clear ? 1'b0 : overrun_q);
        frame_err_d = fe_set ? 1'b1 : (err_clear ? 1'b0 : frame_err_q);
    end

    // State registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_WAIT;
            count_q     <= '0;
            shift_q     <= '0;
            dcw_q       <= 1'b0;
            done_q      <= 1'b0;
            flush_q     <= '0;
            data_q      <= '0;
            put_q       <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            dcw_q       <= dcw_d;
            done_q      <= done_d;
            flush_q     <= flush_d;
            data_q      <= data_d;
            put_q       <= put_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign data      = data_q;
    assign put       = put_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q == S_SHIFT) && !cs_s && (count_q != '0);

endmodule

// File: tb/tb_spi_display_rx.sv
// Directed bench for spi_display_rx: single word, back-to-back words, framing
// error, overrun, reset mid-transfer and a multi-word sequence.
module tb_spi_display_rx;

    localparam int unsigned BITS = 8;
    localparam int unsigned SYNC = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cs_n = 1'b1;
    logic       sclk = 1'b0;
    logic       dc = 1'b0;
    logic       mosi = 1'b0;
    logic       full = 1'b0;
    logic       err_clear = 1'b0;
    logic [8:0] data;
    logic       put;
    logic       overrun;
    logic       frame_err;
    logic       busy;

    int         checks = 0;
    int         failures = 0;
    int         put_cnt = 0;
    logic [8:0] got_q[$];

    spi_display_rx #(.BITS(BITS), .SYNC(SYNC)) dut (
        .clock    (clock),
        .reset    (reset),
        .spi_cs_n (cs_n),
        .spi_clock(sclk),
        .spi_dc   (dc),
        .spi_mosi (mosi),
        .data     (data),
        .put      (put),
        .full     (full),
        .overrun  (overrun),
        .frame_err(frame_err),
        .err_clear(err_clear),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    // Record every delivered word.
    always @(negedge clock) begin
        if (put === 1'b1) begin
            put_cnt++;
            got_q.push_back(data);
        end
    end

    task automatic settle(input int n);
        repeat (n) @(negedge clock);
        #2;
    endtask

    task automatic send_bit(input logic b, input logic d);
        mosi = b;
        dc   = d;
        settle(1);
        sclk = 1'b1;
        settle(4);
        sclk = 1'b0;
        settle(4);
    endtask

    task automatic send_word(input logic [8:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i], w[8]);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        settle(4);
    endtask

    task automatic cs_high();
        cs_n = 1'b1;
        settle(6);
    endtask

    task automatic pulse_clear();
        err_clear = 1'b1;
        settle(1);
        err_clear = 1'b0;
        settle(2);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        settle(3);
        reset = 1'b0;
        settle(3);
        checks++;
        if (data !== 9'h000) begin failures++; $display("FAIL reset_data got=%h exp=000", data); end
        checks++;
        if ({put, overrun, frame_err, busy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=0000", {put, overrun, frame_err, busy});
        end
    endtask

    task automatic test_single_word();
        int p0;
        logic [8:0] w;
        p0 = put_cnt;
        w  = 9'h0A5;
        cs_low();
        for (int i = 7; i >= 1; i--) begin
            send_bit(w[i], w[8]);
            if (i == 4) begin
                checks++;
                if (busy !== 1'b1) begin failures++; $display("FAIL t1_busy_mid got=%b exp=1", busy); end
            end
        end
        // Last bit: check put timing relative to the first clock seeing sclk high.
        mosi = w[0];
        dc   = w[8];
        settle(1);
        sclk = 1'b1;
        repeat (SYNC + 1) @(posedge clock);
        #1;
        checks++;
        if (put !== 1'b0) begin failures++; $display("FAIL t1_put_early got=%b exp=0", put); end
        @(posedge clock);
        #1;
        checks++;
        if (put !== 1'b1) begin failures++; $display("FAIL t1_put_latency got=%b exp=1", put); end
        @(posedge clock);
        #1;
        checks++;
        if (put !== 1'b0) begin failures++; $display("FAIL t1_put_width got=%b exp=0", put); end
        settle(2);
        sclk = 1'b0;
        settle(4);
        checks++;
        if (put_cnt !== p0 + 1) begin failures++; $display("FAIL t1_put_count got=%0d exp=%0d", put_cnt, p0 + 1); end
        checks++;
        if (data !== 9'h0A5) begin failures++; $display("FAIL t1_data got=%h exp=0a5", data); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL t1_busy_end got=%b exp=0", busy); end
        cs_high();
    endtask

    task automatic test_back_to_back();
        int p0;
        int b;
        logic [8:0] v0, v1;
        p0 = put_cnt;
        b  = got_q.size();
        cs_low();
        send_word(9'h13C);
        send_word(9'h1FF);
        cs_high();
        v0 = (got_q.size() > b)     ? got_q[b]     : 9'hxxx;
        v1 = (got_q.size() > b + 1) ? got_q[b + 1] : 9'hxxx;
        checks++;
        if (put_cnt !== p0 + 2) begin failures++; $display("FAIL t2_put_count got=%0d exp=%0d", put_cnt, p0 + 2); end
        checks++;
        if (v0 !== 9'h13C) begin failures++; $display("FAIL t2_word0 got=%h exp=13c", v0); end
        checks++;
        if (v1 !== 9'h1FF) begin failures++; $display("FAIL t2_word1 got=%h exp=1ff", v1); end
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL t2_no_frame_err got=%b exp=0", frame_err); end
    endtask

    task automatic test_frame_error();
        int p0;
        p0 = put_cnt;
        cs_low();
        for (int i = 0; i < 5; i++) send_bit(i[0], 1'b0);
        cs_high();
        checks++;
        if (put_cnt !== p0) begin failures++; $display("FAIL t3_partial_put got=%0d exp=%0d", put_cnt, p0); end
        checks++;
        if (frame_err !== 1'b1) begin failures++; $display("FAIL t3_frame_err_set got=%b exp=1", frame_err); end
        cs_low();
        send_word(9'h012);
        cs_high();
        checks++;
        if (put_cnt !== p0 + 1) begin failures++; $display("FAIL t3_recover_count got=%0d exp=%0d", put_cnt, p0 + 1); end
        checks++;
        if (data !== 9'h012) begin failures++; $display("FAIL t3_recover_data got=%h exp=012", data); end
        checks++;
        if (frame_err !== 1'b1) begin failures++; $display("FAIL t3_frame_err_sticky got=%b exp=1", frame_err); end
        pulse_clear();
        checks++;
        if (frame_err !== 1'b0) begin failures++; $display("FAIL t3_frame_err_clear got=%b exp=0", frame_err); end
    endtask

    task automatic test_overrun();
        int p0;
        p0 = put_cnt;
        full = 1'b1;
        cs_low();
        send_word(9'h055);
        settle(2);
        checks++;
        if (put_cnt !== p0) begin failures++; $display("FAIL t4_put_when_full got=%0d exp=%0d", put_cnt, p0); end
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL t4_overrun_set got=%b exp=1", overrun); end
        full = 1'b0;
        settle(2);
        send_word(9'h066);
        cs_high();
        checks++;
        if (put_cnt !== p0 + 1) begin failures++; $display("FAIL t4_after_full_count got=%0d exp=%0d", put_cnt, p0 + 1); end
        checks++;
        if (data !== 9'h066) begin failures++; $display("FAIL t4_after_full_data got=%h exp=066", data); end
        checks++;
        if (overrun !== 1'b1) begin failures++; $display("FAIL t4_overrun_sticky got=%b exp=1", overrun); end
        pulse_clear();
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL t4_overrun_clear got=%b exp=0", overrun); end
    endtask

    task automatic test_reset_mid_transfer();
        int p0;
        cs_low();
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        reset = 1'b1;
        settle(1);
        reset = 1'b0;
        p0 = put_cnt;
        for (int i = 0; i < 5; i++) send_bit(~i[0], 1'b0);
        settle(6);
        checks++;
        if (put_cnt !== p0) begin failures++; $display("FAIL t5_wait_put got=%0d exp=%0d", put_cnt, p0); end
        checks++;
        if ({busy, frame_err} !== 2'b00) begin
            failures++;
            $display("FAIL t5_wait_flags got=%b exp=00", {busy, frame_err});
        end
        cs_high();
        cs_low();
        send_word(9'h081);
        cs_high();
        checks++;
        if (put_cnt !== p0 + 1) begin failures++; $display("FAIL t5_resync_count got=%0d exp=%0d", put_cnt, p0 + 1); end
        checks++;
        if (data !== 9'h081) begin failures++; $display("FAIL t5_resync_data got=%h exp=081", data); end
    endtask

    task automatic test_sequence();
        logic [8:0] seq [6];
        int b;
        logic [8:0] v;
        seq[0] = 9'h100; seq[1] = 9'h0FF; seq[2] = 9'h155;
        seq[3] = 9'h0AA; seq[4] = 9'h101; seq[5] = 9'h080;
        b = got_q.size();
        cs_low();
        for (int i = 0; i < 6; i++) send_word(seq[i]);
        cs_high();
        checks++;
        if (got_q.size() !== b + 6) begin
            failures++;
            $display("FAIL t6_seq_count got=%0d exp=%0d", got_q.size() - b, 6);
        end
        for (int i = 0; i < 6; i++) begin
            v = (got_q.size() > b + i) ? got_q[b + i] : 9'hxxx;
            checks++;
            if (v !== seq[i]) begin failures++; $display("FAIL t6_seq_word%0d got=%h exp=%h", i, v, seq[i]); end
        end
        checks++;
        if ({overrun, frame_err} !== 2'b00) begin
            failures++;
            $display("FAIL t6_seq_errors got=%b exp=00", {overrun, frame_err});
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_frame_error();
        test_overrun();
        test_reset_mid_transfer();
        test_sequence();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
